demux_1x8_reg: RTL and testbench
================================

// Module: demux_1x8_reg
// PURPOSE
//   Registered 1-to-8 demultiplexer with per-destination holding registers.
//   Routes one W-bit word per cycle to the slot chosen by {s2,s1,s0}.
//   Each slot holds its word and valid flag until the consumer acknowledges it.
//   Feeds the multi-cycle CPU datapath's eight destination latches (write-back/operand staging).
// PARAMETERS
//   W    8    data width of the input word and of each output slot
// PORTS
//   clk        in   1    system clock, rising edge
//   reset      in   1    asynchronous, active-high reset
//   s0,s1,s2   in   1    slot select, index = {s2,s1,s0} (s0 = LSB)
//   in         in   W    data word to route
//   in_valid   in   1    producer offers in at selected slot this cycle
//   in_ready   out  1    selected slot can accept this cycle (combinational)
//   out0..out7 out  W    slot holding registers
//   out_valid  out  8    bit i = slot i holds unconsumed data
//   out_ack    in   8    bit i = consumer takes slot i this cycle
//   count      out  4    number of valid slots, 0..8
//   drop_err   out  1    sticky: a word was offered to a full slot
// BEHAVIOUR
//   Reset (async, immediate): out0..out7=0, out_valid=0, count=0, drop_err=0.
//     Any in-flight transfer is discarded. No output changes until the first clk edge after reset deasserts.
//   sel = {s2,s1,s0}.
//   in_ready = ~out_valid[sel] | out_ack[sel].
//     Purely combinational: a full slot is writable in the same cycle it is acked.
//   Accept: in_valid & in_ready at a rising edge.
//     out<sel> <= in; out_valid[sel] <= 1.
//     One-cycle latency: data and valid are visible in the cycle after the accepting edge.
//   Consume: out_ack[i] & out_valid[i] at a rising edge sets out_valid[i] <= 0 (unless the same slot is accepted).
//     out<i> keeps its last value; data is not cleared.
//     out_ack[i] on an invalid slot is ignored and does not change count.
//   Same slot accepted and acked in one cycle: out_valid stays 1, data is replaced, count unchanged.
//   Multiple acks in one cycle are all honoured; at most one accept per cycle.
//   count: next = count + accept - (number of valid slots acked). Exclusions:
//     the same-slot refill case counts as +0.
//     No wrap: range is 0..8 by construction, and reaching 8 is legal.
//   Drop: in_valid & ~in_ready sets drop_err <= 1. Slot data and count are untouched.
//     drop_err clears only on reset.
//   in_valid=0: no slot writes, regardless of select lines.
//   Select lines may change every cycle and are sampled only at the accepting edge.
// TESTING
//   1. Reset, then offer in=8'hA5 with sel=3, in_valid=1 for one cycle
//      -> next cycle out3=A5, out_valid=8'h08, count=1.
//   2. Fill all 8 slots with values 8'h10..8'h17, no acks
//      -> out_valid=8'hFF, count=8. Then offer sel=0 -> in_ready=0, drop_err=1, out0 still 8'h10.
//   3. Slot 5 full; ack[5]=1 and offer in=8'h3C at sel=5 in the same cycle
//      -> out5=3C, out_valid[5]=1, count unchanged.
//   4. out_valid=8'h81; out_ack=8'hFF for one cycle
//      -> out_valid=0, count=0, out0/out7 retain their data.
//   5. Assert reset between clock edges mid-burst
//      -> all outputs 0 immediately; first post-reset write lands after one edge.
//   6. in_valid=0 while toggling s0..s2 and out_ack on empty slots
//      -> no state change, drop_err stays 0.

Source files
------------

// File: rtl/demux_1x8_reg_if.sv
// demux_1x8_reg_if: producer/consumer bus of the registered 1-to-8 demultiplexer
interface demux_1x8_reg_if #(parameter int W = 8);
  logic         s0, s1, s2;
  logic [W-1:0] in;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out0, out1, out2, out3, out4, out5, out6, out7;
  logic [7:0]   out_valid;
  logic [7:0]   out_ack;
  logic [3:0]   count;
  logic         drop_err;
  modport master (
    output s0, s1, s2, in, in_valid, out_ack,
    input  in_ready, out0, out1, out2, out3, out4, out5, out6, out7, out_valid, count, drop_err
  );
  modport slave (
    input  s0, s1, s2, in, in_valid, out_ack,
    output in_ready, out0, out1, out2, out3, out4, out5, out6, out7, out_valid, count, drop_err
  );
endinterface

// File: rtl/demux_1x8_reg.sv
// demux_1x8_reg: registered 1-to-8 demux with per-slot holding registers and ack-based release
module demux_1x8_reg #(parameter int W = 8) (
  input logic            clk,
  input logic            reset,
  demux_1x8_reg_if.slave bus
);
  logic [2:0]   sel;
  logic         accept;
  logic [7:0]   acked;
  logic [7:0]   next_valid;
  logic [7:0]   valid;
  logic [3:0]   cnt;
  logic         drop;
  logic [W-1:0] data [8];
  assign sel          = {bus.s2, bus.s1, bus.s0};
  assign bus.in_ready = ~valid[sel] | bus.out_ack[sel];
  assign accept       = bus.in_valid & bus.in_ready;
  assign acked        = bus.out_ack & valid;
  // a same-slot refill re-sets the bit the ack just cleared, so count stays put
  assign next_valid   = (valid & ~acked) | (accept ? 8'(1) << sel : 8'h00);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      valid <= '0;
      cnt   <= '0;
      drop  <= 1'b0;
      for (int i = 0; i < 8; i++) data[i] <= '0;
    end else begin
      valid <= next_valid;
      cnt   <= 4'($countones(next_valid));
      drop  <= drop | (bus.in_valid & ~bus.in_ready);
      if (accept) data[sel] <= bus.in;
    end
  assign bus.out_valid = valid;
  assign bus.count     = cnt;
  assign bus.drop_err  = drop;
  assign bus.out0      = data[0];
  assign bus.out1      = data[1];
  assign bus.out2      = data[2];
  assign bus.out3      = data[3];
  assign bus.out4      = data[4];
  assign bus.out5      = data[5];
  assign bus.out6      = data[6];
  assign bus.out7      = data[7];
endmodule

// File: tb/tb_demux_1x8_reg.sv
// tb_demux_1x8_reg: directed self-checking bench for demux_1x8_reg
module tb_demux_1x8_reg;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  demux_1x8_reg_if #(.W(8)) bus ();
  demux_1x8_reg #(.W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic set_sel(input int s);
    {bus.s2, bus.s1, bus.s0} = s[2:0];
  endtask
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    set_sel(0);
    bus.in = '0;
    bus.in_valid = 1'b0;
    bus.out_ack = '0;
    @(negedge clk);
    #1;
    chk("rst_valid", 32'(bus.out_valid), 32'h00);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_drop", 32'(bus.drop_err), 32'd0);
    chk("rst_out3", 32'(bus.out3), 32'h00);
    reset = 1'b0;
    // 1: single write to slot 3
    set_sel(3); bus.in = 8'hA5; bus.in_valid = 1'b1;
    #1 chk("t1_ready", 32'(bus.in_ready), 32'd1);
    tick;
    bus.in_valid = 1'b0;
    #1;
    chk("t1_out3", 32'(bus.out3), 32'hA5);
    chk("t1_valid", 32'(bus.out_valid), 32'h08);
    chk("t1_count", 32'(bus.count), 32'd1);
    reset = 1'b1;
    #1 reset = 1'b0;
    // 2: fill all slots, then overflow slot 0
    for (int i = 0; i < 8; i++) begin
      set_sel(i); bus.in = 8'(8'h10 + i); bus.in_valid = 1'b1;
      tick;
    end
    bus.in_valid = 1'b0;
    #1;
    chk("t2_valid", 32'(bus.out_valid), 32'hFF);
    chk("t2_count", 32'(bus.count), 32'd8);
    chk("t2_out6", 32'(bus.out6), 32'h16);
    set_sel(0); bus.in = 8'h99; bus.in_valid = 1'b1;
    #1 chk("t2_ready", 32'(bus.in_ready), 32'd0);
    tick;
    bus.in_valid = 1'b0;
    #1;
    chk("t2_drop", 32'(bus.drop_err), 32'd1);
    chk("t2_out0", 32'(bus.out0), 32'h10);
    chk("t2_cnt_drop", 32'(bus.count), 32'd8);
    // 3: same-slot ack and refill
    set_sel(5); bus.in = 8'h3C; bus.in_valid = 1'b1; bus.out_ack = 8'h20;
    #1 chk("t3_ready", 32'(bus.in_ready), 32'd1);
    tick;
    bus.in_valid = 1'b0; bus.out_ack = 8'h00;
    #1;
    chk("t3_out5", 32'(bus.out5), 32'h3C);
    chk("t3_valid", 32'(bus.out_valid), 32'hFF);
    chk("t3_count", 32'(bus.count), 32'd8);
    // 4: multi-ack down to 0x81, then ack everything
    bus.out_ack = 8'h7E;
    tick;
    #1;
    chk("t4_valid81", 32'(bus.out_valid), 32'h81);
    chk("t4_count2", 32'(bus.count), 32'd2);
    bus.out_ack = 8'hFF;
    tick;
    bus.out_ack = 8'h00;
    #1;
    chk("t4_valid0", 32'(bus.out_valid), 32'h00);
    chk("t4_count0", 32'(bus.count), 32'd0);
    chk("t4_out0", 32'(bus.out0), 32'h10);
    chk("t4_out7", 32'(bus.out7), 32'h17);
    chk("t4_drop_sticky", 32'(bus.drop_err), 32'd1);
    // 5: async reset mid-burst
    set_sel(1); bus.in = 8'h55; bus.in_valid = 1'b1;
    tick;
    set_sel(4); bus.in = 8'h66;
    #2 reset = 1'b1;
    #1;
    chk("t5_valid", 32'(bus.out_valid), 32'h00);
    chk("t5_count", 32'(bus.count), 32'd0);
    chk("t5_drop", 32'(bus.drop_err), 32'd0);
    chk("t5_out1", 32'(bus.out1), 32'h00);
    chk("t5_out0", 32'(bus.out0), 32'h00);
    @(negedge clk);
    reset = 1'b0;
    set_sel(2); bus.in = 8'h42;
    #1 chk("t5_pre_out2", 32'(bus.out2), 32'h00);
    tick;
    bus.in_valid = 1'b0;
    #1;
    chk("t5_out2", 32'(bus.out2), 32'h42);
    chk("t5_valid2", 32'(bus.out_valid), 32'h04);
    chk("t5_count1", 32'(bus.count), 32'd1);
    // 6: idle with wandering select and acks on empty slots
    for (int i = 0; i < 8; i++) begin
      set_sel(i); bus.in = 8'(8'hE0 + i); bus.out_ack = 8'hFB;
      tick;
    end
    bus.out_ack = 8'h00;
    #1;
    chk("t6_valid", 32'(bus.out_valid), 32'h04);
    chk("t6_count", 32'(bus.count), 32'd1);
    chk("t6_drop", 32'(bus.drop_err), 32'd0);
    chk("t6_out2", 32'(bus.out2), 32'h42);
    chk("t6_out5", 32'(bus.out5), 32'h00);
    // accept plus acks aimed only at empty slots
    set_sel(1); bus.in = 8'h77; bus.in_valid = 1'b1; bus.out_ack = 8'hF0;
    tick;
    bus.in_valid = 1'b0; bus.out_ack = 8'h00;
    #1;
    chk("t7_valid", 32'(bus.out_valid), 32'h06);
    chk("t7_count", 32'(bus.count), 32'd2);
    chk("t7_out1", 32'(bus.out1), 32'h77);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
